// File: rtl/weight_fetch_ctrl_if.sv
// BRAM read-port bus and weight output stream shared by the fetch controller
// and its environment (BRAM banks on one side, MAC array on the other).
interface weight_fetch_ctrl_if #(
    parameter int NUM_BANKS  = 4,
    parameter int WORD_WIDTH = 1280,
    parameter int ADDR_WIDTH = 12
);
    logic [NUM_BANKS*WORD_WIDTH-1:0] weight_from_bram;
    logic [NUM_BANKS*ADDR_WIDTH-1:0] bram_address;
    logic [NUM_BANKS-1:0]            bram_en;
    logic                            read_en;
    logic [WORD_WIDTH-1:0]           weight_out;
    logic                            data_valid;
    logic                            word_last;

    modport master (
        input  weight_from_bram,
        input  read_en,
        output bram_address,
        output bram_en,
        output weight_out,
        output data_valid,
        output word_last
    );

    modport slave (
        output weight_from_bram,
        output read_en,
        input  bram_address,
        input  bram_en,
        input  weight_out,
        input  data_valid,
        input  word_last
    );
endinterface

// File: rtl/weight_fetch_ctrl.sv
// Multi-bank weight fetch controller: reads a group of up to NUM_BANKS words per
// BRAM access inside a wrapping address window and streams them to the MAC array.
module weight_fetch_ctrl #(
    parameter int MAC_NUM            = 256,
    parameter int WEIGHT_WIDTH       = 5,
    parameter int BRAM_ADDRESS_WIDTH = 12,
    parameter int NUM_BANKS          = 4,
    parameter int READ_LATENCY       = 1,
    parameter int LEN_WIDTH          = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    weight_fetch_ctrl_if.master           bus,
    input  logic                          start,
    input  logic                          stop,
    input  logic [BRAM_ADDRESS_WIDTH-1:0] start_address,
    input  logic [BRAM_ADDRESS_WIDTH-1:0] end_address,
    input  logic [LEN_WIDTH-1:0]          read_len,
    output logic                          wrap,
    output logic                          busy
);
    localparam int W     = WEIGHT_WIDTH * MAC_NUM;
    localparam int AW    = BRAM_ADDRESS_WIDTH;
    localparam int CNT_W = 2;
    localparam int IDX_W = $clog2(NUM_BANKS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t               state_r, state_n;
    logic [AW-1:0]        base_r, base_n;
    logic [AW-1:0]        start_q_r, start_q_n;
    logic [AW-1:0]        end_q_r, end_q_n;
    logic [LEN_WIDTH-1:0] idx_r, idx_n;
    logic [LEN_WIDTH-1:0] len_r, len_n;
    logic [CNT_W-1:0]     cnt_r, cnt_n;
    logic                 wrap_n;
    logic [AW:0]          nb_s;

    logic [NUM_BANKS-1:0]    bram_en_r, bram_en_n;
    logic [NUM_BANKS*AW-1:0] bram_address_r, bram_address_n;
    logic                    data_valid_r, word_last_r, wrap_r, busy_r;
    logic [W-1:0]            bank_s [NUM_BANKS];

    // A zero length still moves one word; lengths beyond the bank count are capped.
    function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
        logic [LEN_WIDTH-1:0] res;
        if (len == {LEN_WIDTH{1'b0}}) begin
            res = LEN_WIDTH'(1'b1);
        end else if (len > LEN_WIDTH'(NUM_BANKS)) begin
            res = LEN_WIDTH'(NUM_BANKS);
        end else begin
            res = len;
        end
        return res;
    endfunction

    // Next-state and datapath update; stop beats start beats read_en in every state.
    always_comb begin
        state_n   = state_r;
        base_n    = base_r;
        start_q_n = start_q_r;
        end_q_n   = end_q_r;
        idx_n     = idx_r;
        len_n     = len_r;
        cnt_n     = cnt_r;
        wrap_n    = 1'b0;
        nb_s      = {1'b0, base_r} + (AW+1)'(len_r);
        if (stop) begin
            state_n = IDLE;
        end else if (start) begin
            start_q_n = start_address;
            end_q_n   = end_address;
            base_n    = start_address;
            idx_n     = {LEN_WIDTH{1'b0}};
            len_n     = clamp_len(read_len);
            state_n   = FETCH;
        end else begin
            case (state_r)
                IDLE: begin
                    state_n = IDLE;
                end
                FETCH: begin
                    cnt_n = {CNT_W{1'b0}};
                    if (READ_LATENCY == 1) begin
                        state_n = VALID;
                    end else begin
                        state_n = WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_r == CNT_W'(READ_LATENCY - 2)) begin
                        state_n = VALID;
                    end else begin
                        cnt_n = cnt_r + 2'd1;
                    end
                end
                VALID: begin
                    if (!bus.read_en) begin
                        state_n = VALID;
                    end else if (idx_r != len_r - LEN_WIDTH'(1'b1)) begin
                        idx_n = idx_r + LEN_WIDTH'(1'b1);
                    end else begin
                        // The group may run past end_address; the wrap applies only afterwards.
                        idx_n   = {LEN_WIDTH{1'b0}};
                        len_n   = clamp_len(read_len);
                        state_n = FETCH;
                        if (nb_s > {1'b0, end_q_r}) begin
                            base_n = start_q_r;
                            wrap_n = 1'b1;
                        end else begin
                            base_n = nb_s[AW-1:0];
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Port enables and addresses for the upcoming cycle; addresses always track base.
    always_comb begin
        bram_en_n      = {NUM_BANKS{1'b0}};
        bram_address_n = {(NUM_BANKS*AW){1'b0}};
        for (int i = 0; i < NUM_BANKS; i++) begin
            bram_address_n[i*AW +: AW] = base_n + AW'(i);
            if ((state_n == FETCH) && (LEN_WIDTH'(i) < len_n)) begin
                bram_en_n[i] = 1'b1;
            end else begin
                bram_en_n[i] = 1'b0;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            base_r    <= {AW{1'b0}};
            start_q_r <= {AW{1'b0}};
            end_q_r   <= {AW{1'b0}};
            idx_r     <= {LEN_WIDTH{1'b0}};
            len_r     <= LEN_WIDTH'(1'b1);
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_n;
            base_r    <= base_n;
            start_q_r <= start_q_n;
            end_q_r   <= end_q_n;
            idx_r     <= idx_n;
            len_r     <= len_n;
            cnt_r     <= cnt_n;
        end
    end

    // Output registers, loaded from the next-state values so they align with state_r.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bram_en_r      <= {NUM_BANKS{1'b0}};
            bram_address_r <= {(NUM_BANKS*AW){1'b0}};
            data_valid_r   <= 1'b0;
            word_last_r    <= 1'b0;
            wrap_r         <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            bram_en_r      <= bram_en_n;
            bram_address_r <= bram_address_n;
            data_valid_r   <= (state_n == VALID);
            word_last_r    <= (state_n == VALID) && (idx_n == len_n - LEN_WIDTH'(1'b1));
            wrap_r         <= wrap_n;
            busy_r         <= (state_n != IDLE);
        end
    end

    // BRAM data only lands in the VALID cycle, so the word mux selects by the registered index.
    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_s[i] = bus.weight_from_bram[i*W +: W];
        end
    end

    assign bus.weight_out   = bank_s[idx_r[IDX_W-1:0]];
    assign bus.bram_en      = bram_en_r;
    assign bus.bram_address = bram_address_r;
    assign bus.data_valid   = data_valid_r;
    assign bus.word_last    = word_last_r;
    assign wrap             = wrap_r;
    assign busy             = busy_r;
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Self-checking bench: two controllers (read latency 1 and 3) on behavioural BRAMs,
// a vector table replayed through a scoreboard, plus cycle-exact corner sequences.
module tb_weight_fetch_ctrl;
    localparam int NB = 4;
    localparam int W  = 20;
    localparam int AW = 12;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } word_t;

    typedef struct packed {
        logic [NB-1:0] mask;
        logic [AW-1:0] base;
        logic          wrap;
    } fetch_t;

    typedef struct {
        logic [AW-1:0] sa;
        logic [AW-1:0] ea;
        logic [2:0]    len;
        int            exp_len;
        int            ngroups;
    } vec_t;

    logic          clk;
    logic          rst_n, start, stop;
    logic [AW-1:0] sa, ea;
    logic [2:0]    rlen;
    logic          wrap1, busy1, wrap3, busy3;
    logic [W-1:0]  m1 [NB];
    logic [W-1:0]  s0 [NB];
    logic [W-1:0]  s1 [NB];
    logic [W-1:0]  s2 [NB];

    int     nvec, nerr;
    bit     mon_on;
    word_t  wq1[$], wq3[$];
    fetch_t fq1[$], fq3[$];
    vec_t   vt [7];

    weight_fetch_ctrl_if #(.NUM_BANKS(NB), .WORD_WIDTH(W), .ADDR_WIDTH(AW)) bus1 ();
    weight_fetch_ctrl_if #(.NUM_BANKS(NB), .WORD_WIDTH(W), .ADDR_WIDTH(AW)) bus3 ();

    weight_fetch_ctrl #(.MAC_NUM(4), .WEIGHT_WIDTH(5), .BRAM_ADDRESS_WIDTH(AW),
                        .NUM_BANKS(NB), .READ_LATENCY(1), .LEN_WIDTH(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .start(start), .stop(stop),
        .start_address(sa), .end_address(ea), .read_len(rlen), .wrap(wrap1), .busy(busy1));

    weight_fetch_ctrl #(.MAC_NUM(4), .WEIGHT_WIDTH(5), .BRAM_ADDRESS_WIDTH(AW),
                        .NUM_BANKS(NB), .READ_LATENCY(3), .LEN_WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .start(start), .stop(stop),
        .start_address(sa), .end_address(ea), .read_len(rlen), .wrap(wrap3), .busy(busy3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word content identifies both the bank and the address it came from.
    function automatic logic [W-1:0] dfun(input int b, input logic [AW-1:0] a);
        return {b[3:0], a, 4'h5};
    endfunction

    function automatic logic [NB-1:0] lmask(input int len);
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) m[i] = (i < len);
        return m;
    endfunction

    // BRAM banks: output appears READ_LATENCY cycles after en and holds while en is low.
    always @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (bus1.bram_en[i]) m1[i] <= dfun(i, bus1.bram_address[i*AW +: AW]);
            if (bus3.bram_en[i]) s0[i] <= dfun(i, bus3.bram_address[i*AW +: AW]);
            s1[i] <= s0[i];
            s2[i] <= s1[i];
        end
    end

    assign bus1.weight_from_bram = {m1[3], m1[2], m1[1], m1[0]};
    assign bus3.weight_from_bram = {s2[3], s2[2], s2[1], s2[0]};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        nvec++;
        nerr++;
        $display("FAIL %s: observed 0x%0h where nothing was expected", name, act);
    endtask

    task automatic chk_fetch(input string n, input logic [NB-1:0] en,
                             input logic [NB*AW-1:0] ad, input logic w, input fetch_t f);
        logic [AW-1:0] ea_v;
        chk({n, " bram_en"}, 64'(en), 64'(f.mask));
        for (int i = 0; i < NB; i++) begin
            ea_v = f.base + AW'(i);
            chk($sformatf("%s addr%0d", n, i), 64'(ad[i*AW +: AW]), 64'(ea_v));
        end
        chk({n, " wrap"}, 64'(w), 64'(f.wrap));
    endtask

    // Scoreboard pop/compare of fetch cycles and accepted words for both controllers.
    task automatic mon();
        fetch_t f;
        word_t  wd;
        if (bus1.bram_en != '0) begin
            if (fq1.size() == 0) flag("d1 unexpected fetch", 64'(bus1.bram_en));
            else begin f = fq1.pop_front(); chk_fetch("d1", bus1.bram_en, bus1.bram_address, wrap1, f); end
        end else if (wrap1) flag("d1 stray wrap", 64'(wrap1));
        if (bus1.data_valid && bus1.read_en) begin
            if (wq1.size() == 0) flag("d1 extra word", 64'(bus1.weight_out));
            else begin
                wd = wq1.pop_front();
                chk("d1 weight", 64'(bus1.weight_out), 64'(wd.data));
                chk("d1 last", 64'(bus1.word_last), 64'(wd.last));
            end
        end
        if (bus3.bram_en != '0) begin
            if (fq3.size() == 0) flag("d3 unexpected fetch", 64'(bus3.bram_en));
            else begin f = fq3.pop_front(); chk_fetch("d3", bus3.bram_en, bus3.bram_address, wrap3, f); end
        end else if (wrap3) flag("d3 stray wrap", 64'(wrap3));
        if (bus3.data_valid && bus3.read_en) begin
            if (wq3.size() == 0) flag("d3 extra word", 64'(bus3.weight_out));
            else begin
                wd = wq3.pop_front();
                chk("d3 weight", 64'(bus3.weight_out), 64'(wd.data));
                chk("d3 last", 64'(bus3.word_last), 64'(wd.last));
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (mon_on) mon();
        @(posedge clk);
        #1;
    endtask

    // Expected fetch/word stream for ng groups plus the prefetch of the next group.
    task automatic gen(input logic [AW-1:0] sa_i, input logic [AW-1:0] ea_i,
                       input int len, input int ng);
        logic [AW-1:0] b;
        logic [AW:0]   nb;
        logic          w;
        fetch_t        f;
        word_t         wd;
        b = sa_i;
        w = 1'b0;
        for (int g = 0; g <= ng; g++) begin
            f = '{mask: lmask(len), base: b, wrap: w};
            fq1.push_back(f);
            fq3.push_back(f);
            if (g < ng) begin
                for (int k = 0; k < len; k++) begin
                    wd = '{data: dfun(k, b + AW'(k)), last: (k == len - 1)};
                    wq1.push_back(wd);
                    wq3.push_back(wd);
                end
            end
            nb = {1'b0, b} + (AW+1)'(len);
            if (nb > {1'b0, ea_i}) begin b = sa_i; w = 1'b1; end
            else begin b = nb[AW-1:0]; w = 1'b0; end
        end
    endtask

    task automatic chk_idle(input string n);
        chk({n, " d1 bram_en"}, 64'(bus1.bram_en), 64'h0);
        chk({n, " d1 addr"}, 64'(bus1.bram_address), 64'h0);
        chk({n, " d1 valid"}, 64'(bus1.data_valid), 64'h0);
        chk({n, " d1 last"}, 64'(bus1.word_last), 64'h0);
        chk({n, " d1 wrap"}, 64'(wrap1), 64'h0);
        chk({n, " d1 busy"}, 64'(busy1), 64'h0);
        chk({n, " d3 addr"}, 64'(bus3.bram_address), 64'h0);
        chk({n, " d3 valid"}, 64'(bus3.data_valid), 64'h0);
        chk({n, " d3 busy"}, 64'(busy3), 64'h0);
    endtask

    initial begin
        vt[0] = '{12'h010, 12'h01F, 3'd3, 3, 6};
        vt[1] = '{12'h010, 12'h017, 3'd4, 4, 3};
        vt[2] = '{12'h020, 12'h022, 3'd0, 1, 5};
        vt[3] = '{12'h040, 12'h04B, 3'd7, 4, 4};
        vt[4] = '{12'hFFE, 12'hFFF, 3'd4, 4, 2};
        vt[5] = '{12'h050, 12'h040, 3'd2, 2, 3};
        vt[6] = '{12'h300, 12'h3FF, 3'd5, 4, 2};

        nvec = 0; nerr = 0; mon_on = 1'b0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        sa = '0; ea = '0; rlen = '0;
        bus1.read_en = 1'b0; bus3.read_en = 1'b0;
        step(); step();
        chk_idle("reset");
        rst_n = 1'b1;
        step();

        // Basic group on the latency-1 controller, cycle exact.
        sa = 12'h010; ea = 12'h01F; rlen = 3'd3; start = 1'b1;
        bus1.read_en = 1'b1; bus3.read_en = 1'b1;
        step(); start = 1'b0;
        chk("basic c1 en", 64'(bus1.bram_en), 64'h7);
        chk("basic c1 addr", 64'(bus1.bram_address), 64'h013_012_011_010);
        for (int c = 2; c <= 4; c++) begin
            step();
            chk($sformatf("basic c%0d valid", c), 64'(bus1.data_valid), 64'h1);
            chk($sformatf("basic c%0d weight", c), 64'(bus1.weight_out),
                64'(dfun(c - 2, 12'h010 + AW'(c - 2))));
            chk($sformatf("basic c%0d last", c), 64'(bus1.word_last), 64'(c == 4));
        end
        step();
        chk("basic c5 en", 64'(bus1.bram_en), 64'h7);
        chk("basic c5 addr", 64'(bus1.bram_address), 64'h016_015_014_013);
        stop = 1'b1; step(); stop = 1'b0; step();

        // Backpressure on the latency-3 controller.
        sa = 12'h200; ea = 12'h2FF; rlen = 3'd2; start = 1'b1;
        bus1.read_en = 1'b0; bus3.read_en = 1'b0;
        step(); start = 1'b0;
        chk("bp c1 en", 64'(bus3.bram_en), 64'h3);
        for (int c = 2; c <= 11; c++) begin
            step();
            chk($sformatf("bp c%0d valid", c), 64'(bus3.data_valid), 64'(c >= 4));
            chk($sformatf("bp c%0d en", c), 64'(bus3.bram_en), 64'h0);
            chk($sformatf("bp c%0d addr", c), 64'(bus3.bram_address), 64'h203_202_201_200);
            if (c >= 4) chk($sformatf("bp c%0d weight", c), 64'(bus3.weight_out), 64'(dfun(0, 12'h200)));
        end
        bus3.read_en = 1'b1;
        step();
        chk("bp resume weight", 64'(bus3.weight_out), 64'(dfun(1, 12'h201)));
        chk("bp resume last", 64'(bus3.word_last), 64'h1);
        step();
        chk("bp next fetch en", 64'(bus3.bram_en), 64'h3);
        chk("bp next fetch addr", 64'(bus3.bram_address), 64'h205_204_203_202);
        stop = 1'b1; step(); stop = 1'b0; step();

        // Priority: stop with start in VALID, then start mid-VALID, then reset mid-VALID.
        sa = 12'h010; ea = 12'h01F; rlen = 3'd3; start = 1'b1;
        bus1.read_en = 1'b1; bus3.read_en = 1'b1;
        step(); start = 1'b0; step();
        sa = 12'h100; start = 1'b1; stop = 1'b1;
        step(); start = 1'b0; stop = 1'b0;
        chk("stop+start busy", 64'(busy1), 64'h0);
        chk("stop+start valid", 64'(bus1.data_valid), 64'h0);
        chk("stop+start en", 64'(bus1.bram_en), 64'h0);
        chk("stop+start base kept", 64'(bus1.bram_address), 64'h013_012_011_010);
        sa = 12'h010; start = 1'b1;
        step(); start = 1'b0; step(); step();
        sa = 12'h100; start = 1'b1;
        step(); start = 1'b0;
        chk("restart en", 64'(bus1.bram_en), 64'h7);
        chk("restart addr", 64'(bus1.bram_address), 64'h103_102_101_100);
        step();
        chk("restart idx0 weight", 64'(bus1.weight_out), 64'(dfun(0, 12'h100)));
        chk("restart idx0 last", 64'(bus1.word_last), 64'h0);
        rst_n = 1'b0;
        step();
        chk_idle("mid reset");
        step(); rst_n = 1'b1; step();

        // Table-driven vectors through the scoreboard.
        mon_on = 1'b1;
        for (int v = 0; v < 7; v++) begin
            gen(vt[v].sa, vt[v].ea, vt[v].exp_len, vt[v].ngroups);
            sa = vt[v].sa; ea = vt[v].ea; rlen = vt[v].len; start = 1'b1;
            bus1.read_en = 1'b1; bus3.read_en = 1'b1;
            step(); start = 1'b0;
            for (int c = 0; c < 600 && (wq1.size() + wq3.size() + fq1.size() + fq3.size()) != 0; c++) begin
                step();
                if (wq1.size() == 0) bus1.read_en = 1'b0;
                if (wq3.size() == 0) bus3.read_en = 1'b0;
            end
            if ((wq1.size() + wq3.size() + fq1.size() + fq3.size()) != 0)
                flag($sformatf("vector %0d timeout, items left", v),
                     64'(wq1.size() + wq3.size() + fq1.size() + fq3.size()));
            stop = 1'b1; step(); stop = 1'b0;
            chk($sformatf("vector %0d d1 busy after stop", v), 64'(busy1), 64'h0);
            chk($sformatf("vector %0d d3 busy after stop", v), 64'(busy3), 64'h0);
            wq1.delete(); wq3.delete(); fq1.delete(); fq3.delete();
        end
        mon_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
